// File: rtl/mest_io_pkg.sv
// Shared field layout and defaults for the mest input/output register blocks.
// The packing helper keeps the status-word layout in one place.
package mest_io_pkg;

  localparam int IO_FLD_W     = 4;
  localparam int IO_WORD_W    = 16;
  localparam int BTN_LVL_LSB  = 0;
  localparam int SW_LVL_LSB   = 4;
  localparam int BTN_EVT_LSB  = 8;
  localparam int SW_EVT_LSB   = 12;
  localparam int DEBOUNCE_DEF = 1000000;
  localparam int CNT_W_DEF    = 20;

  function automatic logic [IO_WORD_W-1:0] pack_word(
    input logic [IO_FLD_W-1:0] btn_lvl,
    input logic [IO_FLD_W-1:0] sw_lvl,
    input logic [IO_FLD_W-1:0] btn_evt,
    input logic [IO_FLD_W-1:0] sw_evt
  );
    logic [IO_WORD_W-1:0] word;
    word = {IO_WORD_W{1'b0}};
    word[BTN_LVL_LSB +: IO_FLD_W] = btn_lvl;
    word[SW_LVL_LSB  +: IO_FLD_W] = sw_lvl;
    word[BTN_EVT_LSB +: IO_FLD_W] = btn_evt;
    word[SW_EVT_LSB  +: IO_FLD_W] = sw_evt;
    return word;
  endfunction

endpackage

// File: rtl/mest_debounce_cell.sv
// Single-bit 2-flop synchroniser plus stable-count debouncer.
// Emits the debounced level and one-cycle rise/fall pulses against its delayed copy.
module mest_debounce_cell
  import mest_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_r;
  logic             stable_r;
  logic             stable_d_r;
  logic [CNT_W-1:0] cnt_r;

  // Synchronise, count stable cycles and accept a new level at terminal count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_r     <= 2'b00;
      stable_r   <= 1'b0;
      stable_d_r <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
    end else begin
      sync_r     <= {sync_r[0], raw};
      stable_d_r <= stable_r;
      if (sync_r[1] == stable_r) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r == TERM_CNT) begin
        stable_r <= sync_r[1];
        cnt_r    <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign level = stable_r;
  assign rise  = stable_r & ~stable_d_r;
  assign fall  = ~stable_r & stable_d_r;

endmodule

// File: rtl/mest_in_reg.sv
// Input-side register block: debounced buttons/switches, sticky event flags,
// and a read-and-clear status word behind a one-cycle read handshake.
module mest_in_reg
  import mest_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic                 i_CLK100MHZ,
  input  logic                 i_rst_n,
  input  logic [IO_FLD_W-1:0]  i_btn,
  input  logic [IO_FLD_W-1:0]  i_sw,
  input  logic                 i_rd_en,
  input  logic                 i_rd_clr,
  output logic [IO_WORD_W-1:0] o_in_reg_data_out,
  output logic                 o_rd_valid,
  output logic                 o_evt
);

  localparam int N_IN = 2 * IO_FLD_W;

  logic [N_IN-1:0]      raw_s;
  logic [N_IN-1:0]      lvl_s;
  logic [N_IN-1:0]      rise_s;
  logic [N_IN-1:0]      fall_s;
  logic [N_IN-1:0]      evt_s;
  logic [N_IN-1:0]      clr_s;
  logic [N_IN-1:0]      flags_nxt_s;
  logic [N_IN-1:0]      flags_r;
  logic [IO_WORD_W-1:0] word_s;
  logic [IO_WORD_W-1:0] data_r;
  logic                 rd_valid_r;
  logic                 evt_r;

  assign raw_s = {i_sw, i_btn};

  for (genvar g = 0; g < N_IN; g++) begin : g_cell
    mest_debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_cell (
      .clk   (i_CLK100MHZ),
      .rst_n (i_rst_n),
      .raw   (raw_s[g]),
      .level (lvl_s[g]),
      .rise  (rise_s[g]),
      .fall  (fall_s[g])
    );
  end

  // Buttons flag on press only; switches flag on either edge.
  assign evt_s  = {rise_s[N_IN-1:IO_FLD_W] | fall_s[N_IN-1:IO_FLD_W],
                   rise_s[IO_FLD_W-1:0]};
  assign word_s = pack_word(lvl_s[IO_FLD_W-1:0], lvl_s[N_IN-1:IO_FLD_W],
                            flags_r[IO_FLD_W-1:0], flags_r[N_IN-1:IO_FLD_W]);

  // Clear only flags returned in this read; a same-cycle event re-sets its flag.
  always_comb begin
    clr_s = {N_IN{1'b0}};
    if (i_rd_en && i_rd_clr) begin
      clr_s = flags_r;
    end else begin
      clr_s = {N_IN{1'b0}};
    end
    flags_nxt_s = (flags_r & ~clr_s) | evt_s;
  end

  // Sticky flags, read data capture, read strobe and event level.
  always_ff @(posedge i_CLK100MHZ) begin
    if (!i_rst_n) begin
      flags_r    <= {N_IN{1'b0}};
      data_r     <= {IO_WORD_W{1'b0}};
      rd_valid_r <= 1'b0;
      evt_r      <= 1'b0;
    end else begin
      flags_r    <= flags_nxt_s;
      rd_valid_r <= i_rd_en;
      evt_r      <= |flags_nxt_s;
      if (i_rd_en) begin
        data_r <= word_s;
      end
    end
  end

  assign o_in_reg_data_out = data_r;
  assign o_rd_valid        = rd_valid_r;
  assign o_evt             = evt_r;

endmodule

// File: tb/tb_mest_in_reg.sv
// Directed bench for mest_in_reg with DEBOUNCE_CYCLES = 4; read data is checked
// against a queue of expected words pushed when each read is issued.
module tb_mest_in_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  btn;
  logic [3:0]  sw;
  logic        rd_en;
  logic        rd_clr;
  logic [15:0] data_out;
  logic        rd_valid;
  logic        evt;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] sb[$];
  logic [15:0] mon_exp;

  always #5 clk = ~clk;

  mest_in_reg #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .i_CLK100MHZ       (clk),
    .i_rst_n           (rst_n),
    .i_btn             (btn),
    .i_sw              (sw),
    .i_rd_en           (rd_en),
    .i_rd_clr          (rd_clr),
    .o_in_reg_data_out (data_out),
    .o_rd_valid        (rd_valid),
    .o_evt             (evt)
  );

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic read_step(input logic clr, input logic [15:0] exp);
    rd_en  = 1'b1;
    rd_clr = clr;
    sb.push_back(exp);
    tick(1);
    check16("rd_valid_hi", {15'b0, rd_valid}, 16'h0001);
  endtask

  task automatic read_end();
    rd_en  = 1'b0;
    rd_clr = 1'b0;
  endtask

  task automatic read_one(input logic clr, input logic [15:0] exp);
    read_step(clr, exp);
    read_end();
    tick(1);
    check16("rd_valid_lo", {15'b0, rd_valid}, 16'h0000);
  endtask

  // Scoreboard: every valid read word must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check16("sb_underflow", {15'b0, rd_valid}, 16'h0000);
      end else begin
        mon_exp = sb.pop_front();
        check16("rd_data", data_out, mon_exp);
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    btn    = 4'h0;
    sw     = 4'h0;
    rd_en  = 1'b0;
    rd_clr = 1'b0;
    tick(3);
    check16("rst_data", data_out, 16'h0000);
    check16("rst_valid", {15'b0, rd_valid}, 16'h0000);
    check16("rst_evt", {15'b0, evt}, 16'h0000);
    rst_n = 1'b1;

    // Idle read
    read_one(1'b0, 16'h0000);
    check16("idle_evt", {15'b0, evt}, 16'h0000);

    // btn[2] held: level appears 6 edges later, flag one edge after that
    btn[2] = 1'b1;
    tick(5);
    read_step(1'b0, 16'h0000);
    read_step(1'b0, 16'h0004);
    read_step(1'b0, 16'h0404);
    check16("btn2_evt", {15'b0, evt}, 16'h0001);
    read_step(1'b1, 16'h0404);
    read_step(1'b0, 16'h0004);
    read_end();
    check16("btn2_evt_clr", {15'b0, evt}, 16'h0000);
    btn[2] = 1'b0;
    tick(10);
    read_one(1'b0, 16'h0000);

    // Short glitch on btn[0] is rejected
    btn[0] = 1'b1;
    tick(3);
    btn[0] = 1'b0;
    tick(10);
    read_one(1'b0, 16'h0000);
    check16("glitch_evt", {15'b0, evt}, 16'h0000);

    // Switch rise and fall both flag
    sw[1] = 1'b1;
    tick(10);
    read_one(1'b1, 16'h2020);
    read_one(1'b0, 16'h0020);
    sw[1] = 1'b0;
    tick(10);
    read_one(1'b0, 16'h2000);
    check16("sw1_evt", {15'b0, evt}, 16'h0001);
    read_one(1'b1, 16'h2000);
    read_one(1'b0, 16'h0000);

    // New press in the same cycle as a read-clear of that flag survives
    btn[3] = 1'b1;
    tick(10);
    read_one(1'b0, 16'h0808);
    btn[3] = 1'b0;
    tick(10);
    read_one(1'b0, 16'h0800);
    btn[3] = 1'b1;
    tick(6);
    read_step(1'b1, 16'h0808);
    check16("race_evt", {15'b0, evt}, 16'h0001);
    read_step(1'b0, 16'h0808);
    read_step(1'b1, 16'h0808);
    read_step(1'b0, 16'h0008);
    read_end();
    check16("race_evt_clr", {15'b0, evt}, 16'h0000);
    btn[3] = 1'b0;
    tick(10);

    // Reset mid-count with a flag set and a read requested
    sw[0] = 1'b1;
    tick(10);
    read_one(1'b0, 16'h1010);
    check16("pre_rst_evt", {15'b0, evt}, 16'h0001);
    btn[1] = 1'b1;
    tick(3);
    rst_n = 1'b0;
    rd_en = 1'b1;
    tick(1);
    rst_n = 1'b1;
    rd_en = 1'b0;
    check16("mid_rst_data", data_out, 16'h0000);
    check16("mid_rst_valid", {15'b0, rd_valid}, 16'h0000);
    check16("mid_rst_evt", {15'b0, evt}, 16'h0000);
    tick(5);
    read_step(1'b0, 16'h0000);
    read_step(1'b0, 16'h0012);
    read_step(1'b0, 16'h1212);
    read_end();
    tick(2);
    check16("post_rst_evt", {15'b0, evt}, 16'h0001);

    check16("sb_drained", 16'(sb.size()), 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mest_in_reg.md
Name: mest_in_reg

Overview:
- Input-side register block for mest_pro_top; the read counterpart of the 16-bit output register.
- Synchronises and debounces the 4 buttons and 4 slide switches.
- Records press and change events in sticky flags.
- Presents a 16-bit read-and-clear status word to the processor through a 1-cycle read handshake, plus a level event flag.

Parameters:
- DEBOUNCE_CYCLES, 1000000, stable cycles required before a debounced input changes (10 ms at 100 MHz); must be >= 2.
- CNT_W, 20, debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES.

Ports:
- i_CLK100MHZ  input  1  system clock; all logic on its rising edge.
- i_rst_n  input  1  synchronous, active-low reset.
- i_btn  input  4  raw asynchronous buttons.
- i_sw  input  4  raw asynchronous slide switches.
- i_rd_en  input  1  read strobe, one cycle per read.
- i_rd_clr  input  1  qualifies i_rd_en; clears the sticky flags that were returned.
- o_in_reg_data_out  output  16  read data, valid when o_rd_valid is 1.
- o_rd_valid  output  1  one-cycle pulse, one cycle after i_rd_en.
- o_evt  output  1  OR of all sticky flags.

Behaviour:
- Reset (i_rst_n = 0 at a clock edge):
  - Synchronisers, debounced levels, counters, sticky flags, o_in_reg_data_out, o_rd_valid and o_evt all go to 0.
  - Reset takes priority over every other event, including a read in progress.
- Synchronisation: each of the 8 inputs passes through a 2-flop synchroniser. Nothing downstream uses raw inputs.
- Debounce, per input:
  - Keep a stable level S, a counter C and the synchronised value Y.
  - If Y == S: C <= 0.
  - If Y != S and C == DEBOUNCE_CYCLES-1: S <= Y, C <= 0.
  - Otherwise C <= C+1.
  - Any glitch back to S before the terminal count restarts the count.
  - Raw-to-S latency is 2 + DEBOUNCE_CYCLES cycles.
- Event detection, from S registered one cycle:
  - Button press = S 0->1 (release is ignored).
  - Switch change = either edge.
  - Each event sets its sticky flag; the flag stays set until cleared by a read.
- Register word:
  - [3:0] button S levels.
  - [7:4] switch S levels.
  - [11:8] button press flags.
  - [15:12] switch change flags.
- Read handshake:
  - i_rd_en = 1 at edge N: the word as it stands at edge N is registered into o_in_reg_data_out, and o_rd_valid = 1 for cycle N+1.
  - o_in_reg_data_out holds its value until the next read.
  - i_rd_en asserted on consecutive cycles gives back-to-back reads, one word per cycle.
  - i_rd_clr is ignored when i_rd_en = 0.
- Clear:
  - With i_rd_en & i_rd_clr, each sticky flag that was 1 in the captured word is cleared at the same edge.
  - A new event on the same flag in that same cycle wins: the flag stays 1 and is not lost.
  - Flags that were 0 in the snapshot are never cleared.
- o_evt is registered and reflects flag state after the same edge.
- A switch held constant produces no events.
- Event detection starts from S = 0 after reset, so an input already high after reset produces exactly one event once debounced.

Decomposition:
- Shared package mest_io_pkg:
  - Bit-field offsets BTN_LVL_LSB = 0, SW_LVL_LSB = 4, BTN_EVT_LSB = 8, SW_EVT_LSB = 12.
  - Field width IO_FLD_W = 4.
  - Default debounce constant.
- One sub-module, mest_debounce_cell:
  - Contains the 2-flop synchroniser, counter and S for a single bit.
  - Outputs the stable level plus rise and fall pulses.
- mest_in_reg instantiates 8 cells in a generate loop and owns the sticky flags, the read logic and o_evt.

Test Plan (DEBOUNCE_CYCLES = 4):
- Reset, then read with no stimulus -> o_rd_valid pulses 1 cycle after i_rd_en; o_in_reg_data_out = 16'h0000; o_evt = 0.
- i_btn[2] driven high and held -> bit 2 sets after 6 cycles; next read returns 16'h0404; o_evt = 1. A read with i_rd_clr returns 16'h0404, and the following read returns 16'h0004.
- i_btn[0] pulses high for 3 cycles only -> no level change, no flag, word stays 16'h0000.
- i_sw[1] 0->1, read-clear, then i_sw[1] 1->0 -> reads in order: 16'h2020, 16'h0020, then 16'h2000 after the fall has been debounced.
- A button press event lands in the same cycle as a read-clear that returns that flag as 1 -> the flag remains 1 afterwards and o_evt stays 1.
- i_rst_n = 0 for one edge in mid-count and with flags set -> all outputs 0 next cycle; the debounce count restarts from 0.
